// File: rtl/lsr_pkg.sv
// Shared types and default sizes for the iterative right-shift unit.
package lsr_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SHW   = 6;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/lsr_unit_lsr1.sv
// One-bit combinational right shift; fill supplies the new MSB.
module lsr1 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] in,
  input  logic             fill,
  output logic [WIDTH-1:0] out
);

  assign out = {fill, {(WIDTH-1){1'b0}}} | (in >> 1);

endmodule

// File: rtl/lsr_unit.sv
// Multi-cycle right shifter, one bit per cycle.
// LSR_UNIT_ASR_EN adds an asr input for sign-filling shifts.
module lsr_unit
  import lsr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
`ifdef LSR_UNIT_ASR_EN
  input  logic             asr,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] nxt;
  logic             fill;
  logic             accept;

  assign accept = start && (state != SHIFT);

`ifdef LSR_UNIT_ASR_EN
  logic sign;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign <= 1'b0;
    end else if (accept) begin
      sign <= asr & in[WIDTH-1];
    end
  end

  assign fill = sign;
`else
  assign fill = 1'b0;
`endif

  lsr1 #(
    .WIDTH(WIDTH)
  ) u_lsr1 (
    .in  (out),
    .fill(fill),
    .out (nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      out   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      unique case (1'b1)
        accept: begin
          out <= in;
          cnt <= shamt;
          if (shamt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        (state == SHIFT): begin
          out <= nxt;
          cnt <= cnt - SHW'(1);
          // Last step: counter is about to hit zero.
          if (cnt == SHW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            busy  <= 1'b1;
          end
        end
        (state == DONE && !start): begin
          state <= IDLE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
